pad_readout_arbiter: RTL and testbench

PAD_READOUT_ARBITER -- requirements
Module: pad_readout_arbiter

---
 rtl/pad_arb_pkg.sv | 15 +
 rtl/pad_rr_grant.sv | 33 +++
 rtl/pad_readout_arbiter.sv | 136 +++++++++++++
 tb/tb_pad_readout_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_arb_pkg.sv
// Shared constants for the pad readout arbiter: pad word layout and the
// channel-index width helper.
package pad_arb_pkg;

  localparam int PAD_DATA_W = 116;
  localparam int BCID_MSB   = 115;
  localparam int BCID_LSB   = 104;
  localparam int HIT_MSB    = 103;
  localparam int BCID_W     = BCID_MSB - BCID_LSB + 1;

  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pad_rr_grant.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping modulo N_CH.
module pad_rr_grant
  import pad_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = ch_idx_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // One spare bit so ptr + offset never overflows before the wrap.
  always_comb begin
    logic [IDX_W:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_CH)) begin
        cand = cand - (IDX_W+1)'(N_CH);
      end
      if (!gnt_valid && req[cand[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pad_readout_arbiter.sv
// Merges N_CH pad-check channels into one registered output stream using
// one-entry holding registers per channel and round-robin arbitration.
module pad_readout_arbiter
  import pad_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = PAD_DATA_W,
  parameter int CNT_W  = 16,
  localparam int IDX_W = ch_idx_w(N_CH)
) (
  input  logic                   clk160,
  input  logic                   reset,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_linked,
  input  logic [N_CH-1:0]        ch_enable,
  input  logic                   clear_cnt,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_ch,
  output logic [BCID_W-1:0]      out_bcid,
  output logic [N_CH*CNT_W-1:0]  drop_cnt
);

  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   linked_q, linked_d;
  logic [DATA_W-1:0] hold_q [N_CH];
  logic [DATA_W-1:0] hold_d [N_CH];
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_ch_q, out_ch_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              loadable;
  logic              grant;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;

  pad_rr_grant #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .req       (pend_q & ch_enable),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    loadable    = !out_valid_q || out_ready;
    grant       = loadable && gnt_valid;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = hold_q[gnt_idx];
      out_ch_d    = gnt_idx;
      rr_ptr_d    = (gnt_idx == IDX_W'(N_CH-1)) ? '0 : gnt_idx + IDX_W'(1);
    end else if (loadable) begin
      out_valid_d = 1'b0;
    end
  end

  // A granted channel may refill in the same cycle; link loss wins over a held word.
  always_comb begin
    logic granted_i;
    logic accept_i;
    granted_i = 1'b0;
    accept_i  = 1'b0;
    pend_d    = pend_q;
    linked_d  = ch_linked;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      granted_i = grant && (gnt_idx == IDX_W'(i));
      accept_i  = ch_valid[i] && ch_linked[i] && ch_enable[i];
      if (granted_i) begin
        pend_d[i] = 1'b0;
      end
      if (accept_i) begin
        if (!pend_q[i] || granted_i) begin
          pend_d[i] = 1'b1;
          hold_d[i] = ch_data[i*DATA_W +: DATA_W];
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (linked_q[i] && !ch_linked[i]) begin
        pend_d[i] = 1'b0;
      end
      if (clear_cnt) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk160) begin
    if (reset) begin
      pend_q      <= '0;
      linked_q    <= '0;
      hold_q      <= '{default: '0};
      cnt_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      pend_q      <= pend_d;
      linked_q    <= linked_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_bcid  = out_data_q[BCID_MSB:BCID_LSB];

endmodule

// File: tb/tb_pad_readout_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural model of
// the pad readout arbiter.
module tb_pad_readout_arbiter;

  localparam int N_CH   = 4;
  localparam int DATA_W = 116;
  localparam int CNT_W  = 16;

  logic                   clk160 = 1'b0;
  logic                   reset;
  logic [N_CH-1:0]        ch_valid;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_linked;
  logic [N_CH-1:0]        ch_enable;
  logic                   clear_cnt;
  logic                   out_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [1:0]             out_ch;
  logic [11:0]            out_bcid;
  logic [N_CH*CNT_W-1:0]  drop_cnt;

  int n_compared = 0;
  int n_failed   = 0;

  // Behavioural model state
  bit               m_pend [N_CH];
  logic [DATA_W-1:0] m_word [N_CH];
  int               m_cnt [N_CH];
  bit               m_link_prev [N_CH];
  bit               m_valid;
  logic [DATA_W-1:0] m_out;
  int               m_ch;
  int               m_ptr;

  pad_readout_arbiter #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk160    (clk160),
    .reset     (reset),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_linked (ch_linked),
    .ch_enable (ch_enable),
    .clear_cnt (clear_cnt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_bcid  (out_bcid),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk160 = ~clk160;

  task automatic cyc();
    @(posedge clk160);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [DATA_W-1:0] w);
    ch_data[ch*DATA_W +: DATA_W] = w;
  endtask

  function automatic logic [DATA_W-1:0] rand_word(input logic [11:0] bcid);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return {bcid, t[103:0]};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return drop_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic pulse_reset();
    reset    = 1'b1;
    ch_valid = '0;
    cyc();
    reset = 1'b0;
  endtask

  // Output-busy setup: park a channel-0 word in the output with out_ready low.
  task automatic park_output(input logic [DATA_W-1:0] w);
    out_ready = 1'b0;
    set_word(0, w);
    ch_valid = 4'b0001;
    cyc();
    ch_valid = '0;
    cyc();
  endtask

  function automatic void model_edge();
    int g;
    bit load;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        m_pend[i] = 0; m_word[i] = '0; m_cnt[i] = 0; m_link_prev[i] = 0;
      end
      m_valid = 0; m_out = '0; m_ch = 0; m_ptr = 0;
      return;
    end
    load = !m_valid || out_ready;
    g = -1;
    if (load) begin
      for (int k = 0; k < N_CH; k++) begin
        int c;
        c = (m_ptr + k) % N_CH;
        if (g < 0 && m_pend[c] && ch_enable[c]) g = c;
      end
    end
    if (g >= 0) begin
      m_valid = 1; m_out = m_word[g]; m_ch = g; m_ptr = (g + 1) % N_CH;
    end else if (load) begin
      m_valid = 0;
    end
    for (int i = 0; i < N_CH; i++) begin
      bit ok;
      bit nxt;
      ok  = ch_valid[i] && ch_linked[i] && ch_enable[i];
      nxt = m_pend[i] && (g != i);
      if (ok) begin
        if (!m_pend[i] || g == i) begin
          nxt = 1;
          m_word[i] = ch_data[i*DATA_W +: DATA_W];
        end else if (m_cnt[i] < 65535) begin
          m_cnt[i]++;
        end
      end
      if (m_link_prev[i] && !ch_linked[i]) nxt = 0;
      if (clear_cnt) m_cnt[i] = 0;
      m_pend[i]      = nxt;
      m_link_prev[i] = ch_linked[i];
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    n_compared++;
    if (out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    n_compared++;
    if (out_data !== '0) begin n_failed++; $display("[TB] FAIL reset_data: got %h want 0", out_data); end
    n_compared++;
    if (out_ch !== 2'd0) begin n_failed++; $display("[TB] FAIL reset_ch: got %0d want 0", out_ch); end
    n_compared++;
    if (out_bcid !== 12'h0) begin n_failed++; $display("[TB] FAIL reset_bcid: got %h want 0", out_bcid); end
    n_compared++;
    if (drop_cnt !== '0) begin n_failed++; $display("[TB] FAIL reset_drop: got %h want 0", drop_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    logic [DATA_W-1:0] w;
    w = rand_word(12'hABC);
    out_ready = 1'b1;
    set_word(2, w);
    ch_valid = 4'b0100;
    cyc();
    ch_valid = '0;
    n_compared++;
    if (out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL single_early: got %b want 0", out_valid); end
    cyc();
    n_compared++;
    if (out_valid !== 1'b1) begin n_failed++; $display("[TB] FAIL single_valid: got %b want 1", out_valid); end
    n_compared++;
    if (out_ch !== 2'd2) begin n_failed++; $display("[TB] FAIL single_ch: got %0d want 2", out_ch); end
    n_compared++;
    if (out_bcid !== 12'hABC) begin n_failed++; $display("[TB] FAIL single_bcid: got %h want abc", out_bcid); end
    n_compared++;
    if (out_data !== w) begin n_failed++; $display("[TB] FAIL single_data: got %h want %h", out_data, w); end
    cyc();
    n_compared++;
    if (out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL single_width: got %b want 0", out_valid); end
  endtask

  task automatic test_fairness();
    int exp_ch;
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) set_word(i, rand_word(12'h100 + 12'(i)));
    ch_valid = 4'hF;
    cyc();
    for (int k = 2; k <= 17; k++) begin
      exp_ch   = (k - 2) % N_CH;
      ch_valid = (k <= 13) ? 4'(1 << exp_ch) : 4'h0;
      cyc();
      n_compared++;
      if (out_valid !== 1'b1 || out_ch !== 2'(exp_ch) || out_bcid !== 12'h100 + 12'(exp_ch)) begin
        n_failed++;
        $display("[TB] FAIL fair_seq[%0d]: got v=%b ch=%0d bcid=%h want v=1 ch=%0d", k, out_valid, out_ch, out_bcid, exp_ch);
      end
    end
    ch_valid = '0;
    cyc();
    n_compared++;
    if (out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL fair_drain: got %b want 0", out_valid); end
    n_compared++;
    if (drop_cnt !== '0) begin n_failed++; $display("[TB] FAIL fair_drops: got %h want 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] w1;
    logic [DATA_W-1:0] p [5];
    pulse_reset();
    out_ready = 1'b0;
    w1 = rand_word(12'h111);
    set_word(1, w1);
    ch_valid = 4'b0010;
    cyc();
    ch_valid = '0;
    cyc();
    for (int n = 0; n < 5; n++) begin
      p[n] = rand_word(12'h200 + 12'(n));
      set_word(0, p[n]);
      ch_valid = 4'b0001;
      cyc();
      ch_valid = '0;
      n_compared++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== w1) begin
        n_failed++;
        $display("[TB] FAIL bp_stable[%0d]: got v=%b ch=%0d data=%h want v=1 ch=1 data=%h", n, out_valid, out_ch, out_data, w1);
      end
      cyc();
    end
    n_compared++;
    if (cnt_of(0) !== 16'd4) begin n_failed++; $display("[TB] FAIL bp_drop0: got %0d want 4", cnt_of(0)); end
    n_compared++;
    if (cnt_of(1) !== 16'd0) begin n_failed++; $display("[TB] FAIL bp_drop1: got %0d want 0", cnt_of(1)); end
    out_ready = 1'b1;
    cyc();
    n_compared++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== p[0]) begin
      n_failed++;
      $display("[TB] FAIL bp_release: got v=%b ch=%0d data=%h want v=1 ch=0 data=%h", out_valid, out_ch, out_data, p[0]);
    end
    cyc();
    n_compared++;
    if (out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation_clear();
    pulse_reset();
    park_output(rand_word(12'h300));
    set_word(1, rand_word(12'h301));
    ch_valid = 4'b0010;
    for (int n = 0; n < 65536 + 4; n++) cyc();
    n_compared++;
    if (cnt_of(1) !== 16'hFFFF) begin n_failed++; $display("[TB] FAIL sat_value: got %h want ffff", cnt_of(1)); end
    clear_cnt = 1'b1;
    cyc();
    clear_cnt = 1'b0;
    n_compared++;
    if (cnt_of(1) !== 16'd0) begin n_failed++; $display("[TB] FAIL sat_clear: got %h want 0", cnt_of(1)); end
    cyc();
    ch_valid = '0;
    n_compared++;
    if (cnt_of(1) !== 16'd1) begin n_failed++; $display("[TB] FAIL sat_restart: got %h want 1", cnt_of(1)); end
    n_compared++;
    if (cnt_of(0) !== 16'd0) begin n_failed++; $display("[TB] FAIL sat_other: got %h want 0", cnt_of(0)); end
  endtask

  task automatic test_link_loss();
    int seen3;
    pulse_reset();
    park_output(rand_word(12'h400));
    set_word(3, rand_word(12'h403));
    ch_valid = 4'b1000;
    cyc();
    ch_valid  = '0;
    ch_linked = 4'b0111;
    cyc();
    ch_linked = 4'hF;
    cyc();
    out_ready = 1'b1;
    seen3 = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (out_valid && out_ch == 2'd3) seen3++;
    end
    n_compared++;
    if (seen3 !== 0) begin n_failed++; $display("[TB] FAIL link_output: got %0d ch3 words want 0", seen3); end
    n_compared++;
    if (cnt_of(3) !== 16'd0) begin n_failed++; $display("[TB] FAIL link_drop: got %0d want 0", cnt_of(3)); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) set_word(i, rand_word(12'h500 + 12'(i)));
    ch_valid = 4'b0010;
    cyc();
    ch_valid = '0;
    cyc();
    cyc();
    out_ready = 1'b0;
    ch_valid  = 4'hF;
    cyc();
    ch_valid = '0;
    cyc();
    n_compared++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2) begin
      n_failed++; $display("[TB] FAIL mid_setup: got v=%b ch=%0d want v=1 ch=2", out_valid, out_ch);
    end
    reset    = 1'b1;
    ch_valid = 4'hF;
    cyc();
    reset     = 1'b0;
    ch_valid  = '0;
    out_ready = 1'b1;
    n_compared++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 2'd0 || drop_cnt !== '0) begin
      n_failed++;
      $display("[TB] FAIL mid_reset: got v=%b ch=%0d data=%h drop=%h want all 0", out_valid, out_ch, out_data, drop_cnt);
    end
    cyc();
    cyc();
    n_compared++;
    if (out_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL mid_ignored: got %b want 0", out_valid); end
    ch_valid = 4'hF;
    cyc();
    ch_valid = '0;
    cyc();
    n_compared++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
      n_failed++; $display("[TB] FAIL mid_first_grant: got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch);
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    model_edge();
    cyc();
    reset = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      ch_valid  = 4'($urandom);
      ch_linked = ($urandom_range(7) == 0) ? 4'($urandom) : 4'hF;
      ch_enable = ($urandom_range(5) == 0) ? 4'($urandom) : 4'hF;
      out_ready = ($urandom_range(2) != 0);
      clear_cnt = ($urandom_range(39) == 0);
      reset     = ($urandom_range(299) == 0);
      for (int i = 0; i < N_CH; i++) set_word(i, rand_word(12'($urandom)));
      model_edge();
      cyc();
      n_compared++;
      if (out_valid !== m_valid) begin
        n_failed++; $display("[TB] FAIL rand_valid[%0d]: got %b want %b", n, out_valid, m_valid);
      end
      if (m_valid) begin
        n_compared++;
        if (out_ch !== 2'(m_ch) || out_data !== m_out) begin
          n_failed++;
          $display("[TB] FAIL rand_word[%0d]: got ch=%0d data=%h want ch=%0d data=%h", n, out_ch, out_data, m_ch, m_out);
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        n_compared++;
        if (cnt_of(i) !== 16'(m_cnt[i])) begin
          n_failed++; $display("[TB] FAIL rand_drop[%0d][%0d]: got %0d want %0d", n, i, cnt_of(i), m_cnt[i]);
        end
      end
    end
    reset     = 1'b0;
    ch_valid  = '0;
    ch_linked = 4'hF;
    ch_enable = 4'hF;
    clear_cnt = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    ch_valid  = '0;
    ch_data   = '0;
    ch_linked = 4'hF;
    ch_enable = 4'hF;
    clear_cnt = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single_word();
    test_fairness();
    test_backpressure();
    test_saturation_clear();
    test_link_loss();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
